// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS run monitor: FSM states, end-of-run causes and
// the default halt instruction (syscall).
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_LOOP    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;

  // Several causes can fire on one clock; halt beats loop beats timeout.
  function automatic cause_e pick_cause(input logic halt_hit, input logic loop_hit,
                                        input logic time_hit);
    if (halt_hit) return CAUSE_HALT;
    if (loop_hit) return CAUSE_LOOP;
    if (time_hit) return CAUSE_TIMEOUT;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Bundles the retire stream, clear, status outputs and trace read port of the
// run monitor. master = CPU/bench side, slave = monitor side.
interface mips_run_monitor_if #(
  parameter int PC_W        = 30,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 32
);
  localparam int IDX_W = $clog2(TRACE_DEPTH);
  localparam int TC_W  = IDX_W + 1;

  logic              clr;
  logic              ret_valid;
  logic [PC_W-1:0]   ret_pc;
  logic [31:0]       ret_instr;
  logic [IDX_W-1:0]  rd_idx;

  logic              done;
  logic [1:0]        done_cause;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;
  logic [PC_W+1:0]   last_pc;
  logic [TC_W-1:0]   trace_count;
  logic [PC_W+1:0]   rd_pc;
  logic [31:0]       rd_instr;
  logic              rd_hit;

  modport master (
    output clr, ret_valid, ret_pc, ret_instr, rd_idx,
    input  done, done_cause, cycle_cnt, instr_cnt, last_pc, trace_count,
           rd_pc, rd_instr, rd_hit
  );

  modport slave (
    input  clr, ret_valid, ret_pc, ret_instr, rd_idx,
    output done, done_cause, cycle_cnt, instr_cnt, last_pc, trace_count,
           rd_pc, rd_instr, rd_hit
  );

endinterface

// File: rtl/mips_trace_ring.sv
// Ring buffer of the most recent DEPTH entries with a saturating fill count and
// a registered read addressed relative to the newest entry (0 = most recent).
module mips_trace_ring #(
  parameter int  W     = 64,
  parameter int  DEPTH = 16,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic          rd_hit,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_word_q;
  logic [IW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_hit_q, rd_hit_d;
  logic [IW-1:0] rd_addr;

  always_comb begin
    wptr_d   = wptr_q;
    count_d  = count_q;
    // Power-of-two depth makes the subtraction wrap modulo DEPTH for free.
    rd_addr  = wptr_q - IW'(1) - rd_idx;
    rd_hit_d = ({1'b0, rd_idx} < count_q);
    if (clr) begin
      wptr_d   = '0;
      count_d  = '0;
      rd_hit_d = 1'b0;
    end else if (wr_en) begin
      wptr_d = wptr_q + IW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      count_q  <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      rd_hit_q <= rd_hit_d;
    end
  end

  // RAM kept reset-free; a same-edge read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wptr_q] <= wr_data;
    rd_word_q <= mem[rd_addr];
  end

  assign rd_data = rd_hit_q ? rd_word_q : '0;
  assign rd_hit  = rd_hit_q;
  assign count   = count_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Retire-stream monitor: cycle/instruction counters, end-of-run detection
// (halt, self-loop, timeout) and a trace of the most recent retires.
module mips_run_monitor
  import mips_dbg_pkg::*;
#(
  parameter int          PC_W        = 30,
  parameter int          TRACE_DEPTH = 16,
  parameter int          CNT_W       = 32,
  parameter int          MAX_CYCLES  = 10000,
  parameter logic [31:0] HALT_INSTR  = DEFAULT_HALT_INSTR,
  parameter int          LOOP_REPEAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  mips_run_monitor_if.slave  bus
);

  localparam int LW    = $clog2(LOOP_REPEAT + 1);
  localparam int TW    = PC_W + 2 + 32;
  localparam int IDX_W = $clog2(TRACE_DEPTH);

  state_e             state_q, state_d;
  cause_e             cause_q, cause_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instr_q, instr_d;
  logic [PC_W+1:0]    last_pc_q, last_pc_d;
  logic [LW-1:0]      loop_q, loop_d;
  logic               retire, hit_h, hit_l, hit_t;
  logic [TW-1:0]      rd_data;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    last_pc_d = last_pc_q;
    loop_d    = loop_q;
    retire    = 1'b0;
    hit_h     = 1'b0;
    hit_l     = 1'b0;
    hit_t     = 1'b0;
    if (bus.clr) begin
      state_d   = ST_WAIT;
      cause_d   = CAUSE_NONE;
      cycle_d   = '0;
      instr_d   = '0;
      last_pc_d = '0;
      loop_d    = '0;
    end else if (state_q != ST_DONE) begin
      retire = bus.ret_valid;
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if (retire) begin
        state_d   = ST_RUN;
        instr_d   = instr_q + CNT_W'(1);
        last_pc_d = {bus.ret_pc, 2'b00};
        // last_pc doubles as the previous retire PC; idle cycles leave it alone.
        if (state_q == ST_WAIT || last_pc_q[PC_W+1:2] != bus.ret_pc)
          loop_d = LW'(1);
        else if (loop_q != '1)
          loop_d = loop_q + LW'(1);
        hit_h = (bus.ret_instr == HALT_INSTR);
        hit_l = (loop_d == LW'(LOOP_REPEAT));
      end
      hit_t = (cycle_q == CNT_W'(MAX_CYCLES - 1));
      if (hit_h || hit_l || hit_t) begin
        state_d = ST_DONE;
        cause_d = pick_cause(hit_h, hit_l, hit_t);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      cause_q   <= CAUSE_NONE;
      cycle_q   <= '0;
      instr_q   <= '0;
      last_pc_q <= '0;
      loop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      last_pc_q <= last_pc_d;
      loop_q    <= loop_d;
    end
  end

  mips_trace_ring #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .wr_en   (retire),
    .wr_data ({bus.ret_pc, 2'b00, bus.ret_instr}),
    .rd_idx  (bus.rd_idx[IDX_W-1:0]),
    .rd_data (rd_data),
    .rd_hit  (bus.rd_hit),
    .count   (bus.trace_count)
  );

  assign bus.done       = (state_q == ST_DONE);
  assign bus.done_cause = cause_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.instr_cnt  = instr_q;
  assign bus.last_pc    = last_pc_q;
  assign bus.rd_pc      = rd_data[TW-1:32];
  assign bus.rd_instr   = rd_data[31:0];

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor with a 4-entry trace and a 20-clock
// timeout so every end-of-run cause can be reached quickly.
module tb_mips_run_monitor;

  localparam int PC_W = 30;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  localparam logic [31:0] HALT = 32'h0000_000C;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BEQ = 32'h1000_FFFF;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_run_monitor_if #(.PC_W(PC_W), .TRACE_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mips_run_monitor #(
    .PC_W        (PC_W),
    .TRACE_DEPTH (DEPTH),
    .CNT_W       (CNT_W),
    .MAX_CYCLES  (20),
    .HALT_INSTR  (HALT),
    .LOOP_REPEAT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [PC_W-1:0] pc, input logic [31:0] ins);
    bus.ret_valid = 1'b1;
    bus.ret_pc    = pc;
    bus.ret_instr = ins;
    tick();
    bus.ret_valid = 1'b0;
    $display("retire pc=%0h instr=%08h -> done=%0d cause=%0d cyc=%0d icnt=%0d",
             pc, ins, bus.done, bus.done_cause, bus.cycle_cnt, bus.instr_cnt);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_pc = '0;
    bus.ret_instr = '0;
    bus.rd_idx = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("post_reset_cycle", bus.cycle_cnt, 0);
    chk("post_reset_done", bus.done, 0);

    // Dirty some state, then an asynchronous mid-cycle reset pulse.
    retire(30'h10, 32'h1);
    tick();
    #3 rst = 1'b1;
    #2;
    chk("async_done", bus.done, 0);
    chk("async_cause", bus.done_cause, 0);
    chk("async_cycle", bus.cycle_cnt, 0);
    chk("async_icnt", bus.instr_cnt, 0);
    chk("async_last_pc", bus.last_pc, 0);
    chk("async_tcount", bus.trace_count, 0);
    chk("async_rd_pc", bus.rd_pc, 0);
    chk("async_rd_instr", bus.rd_instr, 0);
    chk("async_rd_hit", bus.rd_hit, 0);
    #18 rst = 1'b0;
    repeat (5) tick();
    chk("wait_cycle5", bus.cycle_cnt, 5);
    chk("wait_done", bus.done, 0);
    chk("wait_icnt", bus.instr_cnt, 0);

    // Halt instruction ends the run; later retires are ignored.
    retire(30'h0, 32'h2008_0005);
    retire(30'h1, 32'h2109_0001);
    chk("halt_pre_done", bus.done, 0);
    retire(30'h2, HALT);
    chk("halt_done", bus.done, 1);
    chk("halt_cause", bus.done_cause, 1);
    chk("halt_icnt", bus.instr_cnt, 3);
    chk("halt_last_pc", bus.last_pc, 32'h8);
    chk("halt_cycle", bus.cycle_cnt, 8);
    retire(30'h3, NOP);
    tick();
    chk("halt_frozen_icnt", bus.instr_cnt, 3);
    chk("halt_frozen_cycle", bus.cycle_cnt, 8);
    chk("halt_frozen_pc", bus.last_pc, 32'h8);

    // Self-loop with idle gaps between the repeats.
    do_clr();
    chk("clr_done", bus.done, 0);
    chk("clr_cause", bus.done_cause, 0);
    chk("clr_cycle", bus.cycle_cnt, 0);
    chk("clr_icnt", bus.instr_cnt, 0);
    retire(30'h3, BEQ);
    tick();
    retire(30'h4, BEQ);
    tick();
    tick();
    retire(30'h4, BEQ);
    chk("loop_two_done", bus.done, 0);
    tick();
    retire(30'h4, BEQ);
    chk("loop_done", bus.done, 1);
    chk("loop_cause", bus.done_cause, 2);
    chk("loop_icnt", bus.instr_cnt, 4);
    chk("loop_cycle", bus.cycle_cnt, 8);
    chk("loop_last_pc", bus.last_pc, 32'h10);

    // Timeout: a retire every clock, distinct PCs, no halt.
    do_clr();
    for (int i = 0; i < 19; i++) retire(30'h100 + 30'(i), NOP);
    chk("tmo_pre_done", bus.done, 0);
    chk("tmo_pre_cycle", bus.cycle_cnt, 19);
    retire(30'h113, NOP);
    chk("tmo_done", bus.done, 1);
    chk("tmo_cause", bus.done_cause, 3);
    chk("tmo_cycle", bus.cycle_cnt, 20);
    chk("tmo_icnt", bus.instr_cnt, 20);
    retire(30'h200, NOP);
    retire(30'h201, HALT);
    chk("tmo_ignored_icnt", bus.instr_cnt, 20);
    chk("tmo_ignored_pc", bus.last_pc, 32'h44C);
    chk("tmo_ignored_cause", bus.done_cause, 3);
    chk("tmo_ignored_cycle", bus.cycle_cnt, 20);

    // Trace wrap and indexed read-back.
    do_clr();
    for (int i = 0; i < 6; i++) retire(30'(i), 32'hA0 + 32'(i));
    chk("trace_count_sat", bus.trace_count, 4);
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      tick();
      $display("read idx=%0d -> hit=%0d pc=%0h instr=%0h", i, bus.rd_hit, bus.rd_pc, bus.rd_instr);
      chk("trace_rd_hit", bus.rd_hit, 1);
      chk("trace_rd_pc", bus.rd_pc, 64'((5 - i) * 4));
      chk("trace_rd_instr", bus.rd_instr, 64'(32'hA5 - 32'(i)));
    end
    bus.rd_idx = '0;
    do_clr();
    chk("clr_rd_hit", bus.rd_hit, 0);
    chk("clr_rd_pc", bus.rd_pc, 0);
    chk("clr_tcount", bus.trace_count, 0);
    tick();
    chk("empty_rd_hit", bus.rd_hit, 0);
    // Same-edge read sees the pre-write (empty) ring.
    retire(30'h7, 32'hB7);
    chk("rbw_rd_hit", bus.rd_hit, 0);
    chk("rbw_tcount", bus.trace_count, 1);
    tick();
    chk("rbw_next_hit", bus.rd_hit, 1);
    chk("rbw_next_pc", bus.rd_pc, 32'h1C);
    chk("rbw_next_instr", bus.rd_instr, 32'hB7);
    bus.rd_idx = 2'd1;
    tick();
    chk("beyond_count_hit", bus.rd_hit, 0);
    chk("beyond_count_instr", bus.rd_instr, 0);

    // Halt, third repeat and timeout all on the same clock: halt wins.
    bus.rd_idx = '0;
    do_clr();
    repeat (17) tick();
    retire(30'h9, NOP);
    retire(30'h9, NOP);
    chk("simul_pre_done", bus.done, 0);
    retire(30'h9, HALT);
    chk("simul_done", bus.done, 1);
    chk("simul_cause", bus.done_cause, 1);
    chk("simul_cycle", bus.cycle_cnt, 20);
    chk("simul_icnt", bus.instr_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_monitor.md
Name: mips_run_monitor

Overview:
- Parametrised simulation/debug monitor for our MIPS cores. Watches the retire stream (PC, IR, retire strobe) and counts cycles and retired instructions.
- Keeps a ring-buffer trace of the last TRACE_DEPTH retires and declares end-of-run on halt instruction, self-loop or timeout.
- Replaces ad-hoc per-cycle PC/IR printing in the CPU benches. The retire strobe lets one monitor serve single-cycle, multicycle and pipelined cores.

Parameters:
PC_W, 30, width of incoming word-address PC; reported byte address is PC_W+2 bits ({pc,2'b00})
TRACE_DEPTH, 16, trace entries; power of two, >=2
CNT_W, 32, width of cycle and instruction counters
MAX_CYCLES, 10000, timeout threshold in clocks (must be < 2^CNT_W)
HALT_INSTR, 32'h0000000C, instruction word treated as halt (syscall)
LOOP_REPEAT, 3, consecutive retires at an identical PC that count as a self-loop halt (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear: restart monitoring without reset
ret_valid  in  1  one instruction retires this cycle
ret_pc  in  PC_W  word address of retiring instruction
ret_instr  in  32  retiring instruction word
done  out  1  run finished (sticky until rst/clr)
done_cause  out  2  0 none, 1 halt instr, 2 self-loop, 3 timeout
cycle_cnt  out  CNT_W  clocks since leaving reset/clr
instr_cnt  out  CNT_W  retired instructions
last_pc  out  PC_W+2  byte address of most recent retire
trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH
rd_idx  in  $clog2(TRACE_DEPTH)  trace read index, 0 = most recent
rd_pc  out  PC_W+2  trace entry byte PC (registered)
rd_instr  out  32  trace entry instruction (registered)
rd_hit  out  1  rd_idx < trace_count at sample time (registered)

Behaviour:
- Reset: asynchronous and active-high; clock clk, reset rst. On rst:
  - state=WAIT.
  - All outputs 0: done, done_cause, cycle_cnt, instr_cnt, last_pc, trace_count, rd_pc, rd_instr, rd_hit.
  - Write pointer 0; loop counter 0.
  - Trace RAM contents need not be cleared; they are masked by trace_count/rd_hit.
- clr, synchronous, takes priority over everything except rst: same register effect as reset.
- States:
  - WAIT: no retire seen yet. First ret_valid moves to RUN.
  - RUN: active monitoring.
  - DONE: terminal; leaves only on rst/clr.
- cycle_cnt: +1 every clock in WAIT and RUN. Frozen in DONE. Saturates at all-ones.
- Retire with ret_valid=1 in WAIT/RUN, same edge:
  - instr_cnt+1.
  - last_pc={ret_pc,2'b00}.
  - Trace write at wptr; wptr+1 mod TRACE_DEPTH; trace_count+1 saturating at TRACE_DEPTH. Wrap overwrites the oldest entry.
- Retires in DONE are ignored: no count, no trace.
- Self-loop counter:
  - Reset to 1 on a retire whose PC differs from the previous retire's PC (or on the first retire).
  - +1 on a retire at the same PC.
  - Retire cycles only; idle cycles do not break the run.
- Done conditions, evaluated each clock in WAIT/RUN:
  - H: ret_valid && ret_instr==HALT_INSTR.
  - L: ret_valid && loop counter would reach LOOP_REPEAT on this retire.
  - T: cycle_cnt == MAX_CYCLES-1 (this clock is the MAX_CYCLES-th).
  - On any of these: next state DONE, done=1 next cycle. Priority for done_cause: H(1) > L(2) > T(3).
  - The terminating retire itself is counted and traced.
- Trace read:
  - rd_pc/rd_instr/rd_hit are registered with 1-cycle latency from rd_idx.
  - Entry address = (wptr-1-rd_idx) mod TRACE_DEPTH.
  - If rd_idx >= trace_count: rd_hit=0, rd_pc=0, rd_instr=0.
  - Read and write on the same edge: the read reflects the pre-write contents (old wptr, old trace_count).
- Reset mid-run: everything returns to WAIT immediately (async), with no partial entries.

Decomposition:
- Shared package mips_dbg_pkg:
  - done_cause encoding constants: CAUSE_NONE/HALT/LOOP/TIMEOUT.
  - State encoding: ST_WAIT/ST_RUN/ST_DONE.
  - Default HALT_INSTR constant.
- One natural sub-module: mips_trace_ring, the ring buffer (write port, wptr, saturating count, registered indexed read) parametrised by width and depth.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset: rst pulse 20 time units mid-cycle -> all outputs 0 asynchronously. After release with no ret_valid for 5 clocks: state WAIT, cycle_cnt=5, done=0.
- Halt: retire PCs 0x0,0x1,0x2 with instrs 0x20080005,0x21090001,0x0000000C -> done=1 next cycle, done_cause=1, instr_cnt=3, last_pc=0x00000008.
- Self-loop: retire 0x3 then 0x4 ×3 (instr 0x1000FFFF), ret_valid gaps between them -> done_cause=2 after third 0x4 retire, instr_cnt=4.
- Timeout: MAX_CYCLES=20, ret_valid every cycle with incrementing PC, no halt -> done at 20th clock, cause=3, cycle_cnt=20; later retires ignored.
- Trace wrap: TRACE_DEPTH=4, 6 retires at PCs 0..5 -> trace_count=4. rd_idx 0..3 gives rd_pc 0x14,0x10,0x0C,0x08 after 1 cycle. After clr, rd_idx=0 gives rd_hit=0.
- Simultaneous causes: HALT_INSTR retired as the 3rd repeat of the same PC on clock MAX_CYCLES -> done_cause=1.
